imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single 32-bit memory port between two requesters: the fetch step (instruction reads) and the load/store unit (data reads/writes).
- Sits between the pipeline steps and the memory model/controller.
- Grants one requester at a time, holds the memory request until the memory acknowledges, then returns a registered response to the owner.
- Includes anti-starvation for fetch and a per-transaction timeout.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte strobes = DATA_W/8)
- MAX_WAIT, 4, cycles fetch may wait while LSU wins before fetch is forced to win
- TIMEOUT, 255, cycles in a WAIT state without mem_ready_i before the transaction is aborted

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- fetch_req_i  in  1  fetch read request; held until fetch_gnt_o
- fetch_addr_i  in  ADDR_W  fetch address
- fetch_gnt_o  out  1  one-cycle grant pulse
- fetch_valid_o  out  1  one-cycle response pulse
- fetch_data_o  out  DATA_W  registered instruction
- lsu_req_i  in  1  LSU request; held until lsu_gnt_o
- lsu_we_i  in  1  1 = write
- lsu_addr_i  in  ADDR_W  LSU address
- lsu_wdata_i  in  DATA_W  write data
- lsu_wstrb_i  in  DATA_W/8  byte strobes
- lsu_gnt_o  out  1  one-cycle grant pulse
- lsu_valid_o  out  1  one-cycle response pulse (reads and writes)
- lsu_rdata_o  out  DATA_W  registered read data (0 for writes)
- mem_req_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_W  latched address
- mem_wdata_o  out  DATA_W  latched write data
- mem_wstrb_o  out  DATA_W/8  latched strobes (0 for reads)
- mem_ready_i  in  1  memory completion; read data valid in the same cycle
- mem_rdata_i  in  DATA_W  memory read data
- busy_o  out  1  state != IDLE
- timeout_o  out  1  one-cycle pulse on abort

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State = IDLE; all outputs = 0; starve counter = 0; timeout counter = 0.
  - Any in-flight transaction is dropped and mem_req_o falls immediately.
  - No response pulse is generated for a dropped transaction.
- States: IDLE, FETCH_WAIT, LSU_WAIT.
- IDLE arbitration, sampled at the clock edge:
  - Only one requester active: that requester wins.
  - Both active: LSU wins, unless starve_cnt >= MAX_WAIT, in which case fetch wins.
- On a win:
  - Latch we/addr/wdata/wstrb into the mem_* registers. Fetch is always a read with wstrb = 0.
  - Enter X_WAIT.
  - Assert X_gnt_o for exactly that first cycle.
  - Assert mem_req_o from that same cycle.
- Starve counter:
  - Increments (saturating at MAX_WAIT) on each edge where fetch_req_i=1 and fetch is not being granted.
  - Clears on fetch grant.
  - Clears when fetch_req_i=0.
- X_WAIT:
  - mem_req_o and the mem_* outputs are stable until completion.
  - On an edge with mem_ready_i=1:
    - Register mem_rdata_i into the owner's data output (LSU writes register 0).
    - Pulse X_valid_o for the following cycle.
    - Clear mem_req_o; return to IDLE.
- Latency: request in cycle 0 → gnt in cycle 1 → ready in cycle 1 earliest → valid in cycle 2. There is a one-cycle IDLE bubble between transactions, so the next grant is cycle 3 at the earliest.
- Timeout:
  - The counter counts WAIT cycles with mem_ready_i=0.
  - When it reaches TIMEOUT: clear mem_req_o, pulse X_valid_o with data = 0, pulse timeout_o in the same cycle, return to IDLE.
  - mem_ready_i asserted on the same edge as the timeout wins; the transaction completes normally.
- Data outputs hold their last value between valid pulses.
- Request inputs are ignored outside IDLE. Requesters keep req high until their gnt, then must deassert unless they issue a new request.
- mem_ready_i while in IDLE is ignored.

Test Plan:
- Fetch only: fetch_addr=0x8000_0000, memory ready one cycle after mem_req_o, rdata=0x0000_0013 → fetch_gnt_o in cycle 1; mem_addr_o=0x8000_0000, mem_we_o=0; fetch_valid_o with fetch_data_o=0x13 two cycles after grant; lsu_valid_o stays 0.
- LSU write: addr=0x8000_1000, wdata=0xDEAD_BEEF, wstrb=0xF, ready immediately → mem_we_o=1 and mem_wdata_o=0xDEADBEEF while mem_req_o=1; lsu_valid_o pulses one cycle with lsu_rdata_o=0.
- Contention: both requesters held continuously, LSU re-requests immediately after each grant, MAX_WAIT=4, one-cycle memory → LSU granted first; fetch granted once starve_cnt reaches 4; starve_cnt returns to 0 afterwards.
- Timeout: TIMEOUT=8, LSU read, mem_ready_i never asserted → mem_req_o high 8 cycles then low; timeout_o and lsu_valid_o pulse together with lsu_rdata_o=0; state returns to IDLE.
- Reset mid-transaction: assert rst_i=0 asynchronously during FETCH_WAIT → mem_req_o, busy_o and all pulses go 0 immediately; no fetch_valid_o after release; a new request is granted normally.
- Ready/timeout race: mem_ready_i first asserted on the TIMEOUT-th cycle → normal completion with the returned data; timeout_o stays 0.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_port_arbiter_if
//  Purpose  : Bundles the fetch, load/store and memory-side handshakes of the
//             shared instruction/data memory port arbiter.
//  Modports : slave  - arbiter view (requests and memory responses in,
//                      grants, responses and memory request out)
//             master - environment view (pipeline steps plus memory model)
//  Signals  : fetch_*  fetch read channel
//             lsu_*    load/store channel
//             mem_*    single shared memory port
//             busy_o, timeout_o  status
//  Revision : 1.0  initial release
// ============================================================================
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch channel
    logic                  fetch_req_i;
    logic [ADDR_W-1:0]     fetch_addr_i;
    logic                  fetch_gnt_o;
    logic                  fetch_valid_o;
    logic [DATA_W-1:0]     fetch_data_o;

    // Load/store channel
    logic                  lsu_req_i;
    logic                  lsu_we_i;
    logic [ADDR_W-1:0]     lsu_addr_i;
    logic [DATA_W-1:0]     lsu_wdata_i;
    logic [DATA_W/8-1:0]   lsu_wstrb_i;
    logic                  lsu_gnt_o;
    logic                  lsu_valid_o;
    logic [DATA_W-1:0]     lsu_rdata_o;

    // Memory port
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic [DATA_W/8-1:0]   mem_wstrb_o;
    logic                  mem_ready_i;
    logic [DATA_W-1:0]     mem_rdata_i;

    // Status
    logic                  busy_o;
    logic                  timeout_o;

    modport slave (
        input  fetch_req_i, fetch_addr_i,
        output fetch_gnt_o, fetch_valid_o, fetch_data_o,
        input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wstrb_i,
        output lsu_gnt_o, lsu_valid_o, lsu_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_ready_i, mem_rdata_i,
        output busy_o, timeout_o
    );

    modport master (
        output fetch_req_i, fetch_addr_i,
        input  fetch_gnt_o, fetch_valid_o, fetch_data_o,
        output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wstrb_i,
        input  lsu_gnt_o, lsu_valid_o, lsu_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_ready_i, mem_rdata_i,
        input  busy_o, timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_port_arbiter
//  Purpose  : Shares one 32-bit memory port between the fetch step and the
//             load/store unit. One owner at a time; the memory request is
//             held until mem_ready_i, then a registered response is returned
//             to the owner. Fetch is protected against starvation and every
//             transaction is aborted after TIMEOUT wait cycles without ready.
//  Ports    : clk_i  clock
//             rst_i  asynchronous active-low reset
//             bus    imem_port_arbiter_if.slave (fetch, lsu, mem, status)
//  Revision : 1.0  initial release
// ============================================================================
module imem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 255
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    imem_port_arbiter_if.slave bus
);
    localparam int c_strb_w   = DATA_W / 8;
    localparam int c_starve_w = $clog2(MAX_WAIT + 1);
    localparam int c_tmo_w    = $clog2(TIMEOUT + 1);

    localparam logic [c_starve_w-1:0] c_starve_sat = c_starve_w'(MAX_WAIT);
    // The abort fires on the edge that would bring the count to TIMEOUT.
    localparam logic [c_tmo_w-1:0]    c_tmo_last   = c_tmo_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_FETCH_WAIT = 2'd1,
        ST_LSU_WAIT   = 2'd2
    } state_t;

    state_t                r_state,       w_state_nxt;
    logic [c_starve_w-1:0] r_starve_cnt,  w_starve_cnt;
    logic [c_tmo_w-1:0]    r_tmo_cnt,     w_tmo_cnt;
    logic                  r_fetch_gnt,   w_fetch_gnt;
    logic                  r_lsu_gnt,     w_lsu_gnt;
    logic                  r_fetch_valid, w_fetch_valid;
    logic                  r_lsu_valid,   w_lsu_valid;
    logic                  r_timeout,     w_timeout;
    logic [DATA_W-1:0]     r_fetch_data,  w_fetch_data;
    logic [DATA_W-1:0]     r_lsu_rdata,   w_lsu_rdata;
    logic                  r_mem_req,     w_mem_req;
    logic                  r_mem_we,      w_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr,    w_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata,   w_mem_wdata;
    logic [c_strb_w-1:0]   r_mem_wstrb,   w_mem_wstrb;

    logic w_fetch_win;
    logic w_lsu_win;

    // LSU has priority on contention until fetch has waited MAX_WAIT edges.
    assign w_fetch_win = (r_state == ST_IDLE) && bus.fetch_req_i &&
                         (!bus.lsu_req_i || (r_starve_cnt >= c_starve_sat));
    assign w_lsu_win   = (r_state == ST_IDLE) && bus.lsu_req_i && !w_fetch_win;

    // Starvation counter tracks every edge a pending fetch is passed over,
    // including edges spent while the port is busy with someone else.
    always_comb begin
        w_starve_cnt = r_starve_cnt;
        if (!bus.fetch_req_i || w_fetch_win) begin
            w_starve_cnt = '0;
        end else if (r_starve_cnt < c_starve_sat) begin
            w_starve_cnt = r_starve_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tmo_cnt     = r_tmo_cnt;
        w_fetch_gnt   = 1'b0;
        w_lsu_gnt     = 1'b0;
        w_fetch_valid = 1'b0;
        w_lsu_valid   = 1'b0;
        w_timeout     = 1'b0;
        w_fetch_data  = r_fetch_data;
        w_lsu_rdata   = r_lsu_rdata;
        w_mem_req     = r_mem_req;
        w_mem_we      = r_mem_we;
        w_mem_addr    = r_mem_addr;
        w_mem_wdata   = r_mem_wdata;
        w_mem_wstrb   = r_mem_wstrb;

        case (r_state)
            ST_IDLE: begin
                if (w_fetch_win) begin
                    w_state_nxt = ST_FETCH_WAIT;
                    w_fetch_gnt = 1'b1;
                    w_mem_req   = 1'b1;
                    w_mem_we    = 1'b0;
                    w_mem_addr  = bus.fetch_addr_i;
                    w_mem_wdata = '0;
                    w_mem_wstrb = '0;
                    w_tmo_cnt   = '0;
                end else if (w_lsu_win) begin
                    w_state_nxt = ST_LSU_WAIT;
                    w_lsu_gnt   = 1'b1;
                    w_mem_req   = 1'b1;
                    w_mem_we    = bus.lsu_we_i;
                    w_mem_addr  = bus.lsu_addr_i;
                    w_mem_wdata = bus.lsu_wdata_i;
                    // Reads never drive strobes onto the memory port.
                    w_mem_wstrb = bus.lsu_we_i ? bus.lsu_wstrb_i : '0;
                    w_tmo_cnt   = '0;
                end
            end

            ST_FETCH_WAIT, ST_LSU_WAIT: begin
                // Ready takes priority over a timeout landing on the same edge.
                if (bus.mem_ready_i) begin
                    if (r_state == ST_FETCH_WAIT) begin
                        w_fetch_valid = 1'b1;
                        w_fetch_data  = bus.mem_rdata_i;
                    end else begin
                        w_lsu_valid   = 1'b1;
                        w_lsu_rdata   = r_mem_we ? '0 : bus.mem_rdata_i;
                    end
                    w_mem_req   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    if (r_state == ST_FETCH_WAIT) begin
                        w_fetch_valid = 1'b1;
                        w_fetch_data  = '0;
                    end else begin
                        w_lsu_valid   = 1'b1;
                        w_lsu_rdata   = '0;
                    end
                    w_timeout   = 1'b1;
                    w_mem_req   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmo_cnt = r_tmo_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_mem_req   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= ST_IDLE;
            r_starve_cnt  <= '0;
            r_tmo_cnt     <= '0;
            r_fetch_gnt   <= 1'b0;
            r_lsu_gnt     <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_lsu_valid   <= 1'b0;
            r_timeout     <= 1'b0;
            r_fetch_data  <= '0;
            r_lsu_rdata   <= '0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrb   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_starve_cnt  <= w_starve_cnt;
            r_tmo_cnt     <= w_tmo_cnt;
            r_fetch_gnt   <= w_fetch_gnt;
            r_lsu_gnt     <= w_lsu_gnt;
            r_fetch_valid <= w_fetch_valid;
            r_lsu_valid   <= w_lsu_valid;
            r_timeout     <= w_timeout;
            r_fetch_data  <= w_fetch_data;
            r_lsu_rdata   <= w_lsu_rdata;
            r_mem_req     <= w_mem_req;
            r_mem_we      <= w_mem_we;
            r_mem_addr    <= w_mem_addr;
            r_mem_wdata   <= w_mem_wdata;
            r_mem_wstrb   <= w_mem_wstrb;
        end
    end

    assign bus.fetch_gnt_o   = r_fetch_gnt;
    assign bus.fetch_valid_o = r_fetch_valid;
    assign bus.fetch_data_o  = r_fetch_data;
    assign bus.lsu_gnt_o     = r_lsu_gnt;
    assign bus.lsu_valid_o   = r_lsu_valid;
    assign bus.lsu_rdata_o   = r_lsu_rdata;
    assign bus.mem_req_o     = r_mem_req;
    assign bus.mem_we_o      = r_mem_we;
    assign bus.mem_addr_o    = r_mem_addr;
    assign bus.mem_wdata_o   = r_mem_wdata;
    assign bus.mem_wstrb_o   = r_mem_wstrb;
    assign bus.busy_o        = (r_state != ST_IDLE);
    assign bus.timeout_o     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_port_arbiter
//  Purpose  : Self-checking bench for imem_port_arbiter. Directed scenarios
//             followed by a randomized run against a transaction-level model
//             (owner selection from request ages, queued transaction fields,
//             last returned data per requester).
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_port_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int TIMEOUT  = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    imem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    logic [139:0] all_out;
    assign all_out = {bus.fetch_gnt_o, bus.fetch_valid_o, bus.fetch_data_o,
                      bus.lsu_gnt_o, bus.lsu_valid_o, bus.lsu_rdata_o,
                      bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
                      bus.mem_wstrb_o, bus.busy_o, bus.timeout_o};

    task automatic drive_idle();
        bus.fetch_req_i  = 1'b0;
        bus.fetch_addr_i = '0;
        bus.lsu_req_i    = 1'b0;
        bus.lsu_we_i     = 1'b0;
        bus.lsu_addr_i   = '0;
        bus.lsu_wdata_i  = '0;
        bus.lsu_wstrb_i  = '0;
        bus.mem_ready_i  = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic apply_reset();
        rst_i = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        drive_idle();
        @(negedge clk_i);
        n_checks++;
        if (all_out !== '0) $display("FAIL reset_outputs got=%h exp=0", all_out);
        else n_pass++;
        // Requests and ready during reset must have no effect.
        bus.fetch_req_i = 1'b1; bus.lsu_req_i = 1'b1; bus.mem_ready_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (all_out !== '0) $display("FAIL reset_ignores_req got=%h exp=0", all_out);
        else n_pass++;
        drive_idle();
        rst_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({bus.busy_o, bus.mem_req_o, bus.fetch_gnt_o, bus.lsu_gnt_o} !== 4'b0000)
            $display("FAIL idle_after_reset got=%b exp=0000",
                     {bus.busy_o, bus.mem_req_o, bus.fetch_gnt_o, bus.lsu_gnt_o});
        else n_pass++;
    endtask

    task automatic test_fetch_only();
        @(negedge clk_i);
        bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 32'h8000_0000;
        @(negedge clk_i);
        n_checks++;
        if ({bus.fetch_gnt_o, bus.lsu_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.busy_o} !== 5'b10101)
            $display("FAIL fetch_grant got=%b exp=10101",
                     {bus.fetch_gnt_o, bus.lsu_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.busy_o});
        else n_pass++;
        n_checks++;
        if ({bus.mem_addr_o, bus.mem_wstrb_o} !== {32'h8000_0000, 4'h0})
            $display("FAIL fetch_mem_addr got=%h/%h exp=80000000/0", bus.mem_addr_o, bus.mem_wstrb_o);
        else n_pass++;
        bus.fetch_req_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({bus.fetch_gnt_o, bus.mem_req_o, bus.fetch_valid_o} !== 3'b010)
            $display("FAIL fetch_hold got=%b exp=010", {bus.fetch_gnt_o, bus.mem_req_o, bus.fetch_valid_o});
        else n_pass++;
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'h0000_0013;
        @(negedge clk_i);
        n_checks++;
        if ({bus.fetch_valid_o, bus.lsu_valid_o, bus.mem_req_o, bus.timeout_o, bus.fetch_data_o} !== {4'b1000, 32'h13})
            $display("FAIL fetch_resp got=%b data=%h exp=1000 data=00000013",
                     {bus.fetch_valid_o, bus.lsu_valid_o, bus.mem_req_o, bus.timeout_o}, bus.fetch_data_o);
        else n_pass++;
        bus.mem_ready_i = 1'b0; bus.mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        n_checks++;
        if ({bus.fetch_valid_o, bus.busy_o, bus.fetch_data_o} !== {2'b00, 32'h13})
            $display("FAIL fetch_data_hold got=%b data=%h exp=00 data=00000013",
                     {bus.fetch_valid_o, bus.busy_o}, bus.fetch_data_o);
        else n_pass++;
    endtask

    task automatic test_lsu_write();
        bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b1; bus.lsu_addr_i = 32'h8000_1000;
        bus.lsu_wdata_i = 32'hDEAD_BEEF; bus.lsu_wstrb_i = 4'hF;
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'h5555_AAAA;
        @(negedge clk_i);
        n_checks++;
        if ({bus.lsu_gnt_o, bus.fetch_gnt_o, bus.mem_req_o, bus.mem_we_o} !== 4'b1011)
            $display("FAIL lsu_wr_grant got=%b exp=1011", {bus.lsu_gnt_o, bus.fetch_gnt_o, bus.mem_req_o, bus.mem_we_o});
        else n_pass++;
        n_checks++;
        if ({bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o} !== {32'h8000_1000, 32'hDEAD_BEEF, 4'hF})
            $display("FAIL lsu_wr_fields got=%h/%h/%h exp=80001000/deadbeef/f",
                     bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o);
        else n_pass++;
        bus.lsu_req_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({bus.lsu_valid_o, bus.fetch_valid_o, bus.mem_req_o, bus.lsu_rdata_o} !== {3'b100, 32'h0})
            $display("FAIL lsu_wr_resp got=%b data=%h exp=100 data=0",
                     {bus.lsu_valid_o, bus.fetch_valid_o, bus.mem_req_o}, bus.lsu_rdata_o);
        else n_pass++;
        drive_idle();
        @(negedge clk_i);
        n_checks++;
        if ({bus.lsu_valid_o, bus.fetch_data_o} !== {1'b0, 32'h13})
            $display("FAIL lsu_wr_pulse got=%b fdata=%h exp=0 fdata=00000013", bus.lsu_valid_o, bus.fetch_data_o);
        else n_pass++;
    endtask

    task automatic test_contention();
        // Expected {fetch_gnt, lsu_gnt} in cycles 1..7 with both requesters held.
        logic [1:0] exp_g [7] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 32'h8000_0100;
        bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = 32'h8000_2000;
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'h0000_1234;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_i);
            n_checks++;
            if ({bus.fetch_gnt_o, bus.lsu_gnt_o} !== exp_g[c-1])
                $display("FAIL contention_gnt cycle=%0d got=%b exp=%b", c, {bus.fetch_gnt_o, bus.lsu_gnt_o}, exp_g[c-1]);
            else n_pass++;
            if (c == 6) begin
                n_checks++;
                if ({bus.fetch_valid_o, bus.fetch_data_o} !== {1'b1, 32'h1234})
                    $display("FAIL contention_fetch_resp got=%b/%h exp=1/00001234", bus.fetch_valid_o, bus.fetch_data_o);
                else n_pass++;
            end
            if (c == 5) bus.fetch_req_i = 1'b0;
            if (c == 6) bus.fetch_req_i = 1'b1;
        end
        bus.fetch_req_i = 1'b0; bus.lsu_req_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({bus.lsu_valid_o, bus.lsu_rdata_o} !== {1'b1, 32'h1234})
            $display("FAIL contention_lsu_resp got=%b/%h exp=1/00001234", bus.lsu_valid_o, bus.lsu_rdata_o);
        else n_pass++;
        bus.mem_ready_i = 1'b0;
    endtask

    task automatic test_timeout();
        @(negedge clk_i);
        bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = 32'h8000_3000;
        bus.mem_ready_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({bus.lsu_gnt_o, bus.mem_req_o} !== 2'b11)
            $display("FAIL timeout_grant got=%b exp=11", {bus.lsu_gnt_o, bus.mem_req_o});
        else n_pass++;
        bus.lsu_req_i = 1'b0;
        for (int c = 2; c <= TIMEOUT; c++) begin
            @(negedge clk_i);
            n_checks++;
            if ({bus.mem_req_o, bus.timeout_o, bus.lsu_valid_o} !== 3'b100)
                $display("FAIL timeout_wait cycle=%0d got=%b exp=100", c, {bus.mem_req_o, bus.timeout_o, bus.lsu_valid_o});
            else n_pass++;
        end
        @(negedge clk_i);
        n_checks++;
        if ({bus.mem_req_o, bus.timeout_o, bus.lsu_valid_o, bus.busy_o, bus.lsu_rdata_o} !== {4'b0110, 32'h0})
            $display("FAIL timeout_abort got=%b data=%h exp=0110 data=0",
                     {bus.mem_req_o, bus.timeout_o, bus.lsu_valid_o, bus.busy_o}, bus.lsu_rdata_o);
        else n_pass++;
        @(negedge clk_i);
        n_checks++;
        if ({bus.timeout_o, bus.lsu_valid_o} !== 2'b00)
            $display("FAIL timeout_pulse got=%b exp=00", {bus.timeout_o, bus.lsu_valid_o});
        else n_pass++;
    endtask

    task automatic test_ready_timeout_race();
        bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 32'h8000_0200; bus.mem_ready_i = 1'b0;
        @(negedge clk_i);
        bus.fetch_req_i = 1'b0;
        for (int c = 1; c < TIMEOUT; c++) begin
            @(negedge clk_i);
            n_checks++;
            if ({bus.mem_req_o, bus.timeout_o, bus.fetch_valid_o} !== 3'b100)
                $display("FAIL race_wait cycle=%0d got=%b exp=100", c + 1, {bus.mem_req_o, bus.timeout_o, bus.fetch_valid_o});
            else n_pass++;
        end
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hABCD_0001;
        @(negedge clk_i);
        n_checks++;
        if ({bus.fetch_valid_o, bus.timeout_o, bus.mem_req_o, bus.fetch_data_o} !== {3'b100, 32'hABCD_0001})
            $display("FAIL race_complete got=%b data=%h exp=100 data=abcd0001",
                     {bus.fetch_valid_o, bus.timeout_o, bus.mem_req_o}, bus.fetch_data_o);
        else n_pass++;
        bus.mem_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 32'h8000_0040;
        @(negedge clk_i);
        n_checks++;
        if ({bus.fetch_gnt_o, bus.busy_o} !== 2'b11)
            $display("FAIL rstmid_grant got=%b exp=11", {bus.fetch_gnt_o, bus.busy_o});
        else n_pass++;
        bus.fetch_req_i = 1'b0;
        #2 rst_i = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_req_o, bus.busy_o, bus.fetch_gnt_o, bus.fetch_valid_o, bus.lsu_valid_o, bus.timeout_o} !== 6'b0)
            $display("FAIL rstmid_async got=%b exp=000000",
                     {bus.mem_req_o, bus.busy_o, bus.fetch_gnt_o, bus.fetch_valid_o, bus.lsu_valid_o, bus.timeout_o});
        else n_pass++;
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hFFFF_0000;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            n_checks++;
            if ({bus.fetch_valid_o, bus.busy_o, bus.mem_req_o} !== 3'b000)
                $display("FAIL rstmid_no_resp cycle=%0d got=%b exp=000", c, {bus.fetch_valid_o, bus.busy_o, bus.mem_req_o});
            else n_pass++;
            bus.mem_ready_i = 1'b0;
        end
        bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = 32'h8000_0080;
        @(negedge clk_i);
        n_checks++;
        if ({bus.lsu_gnt_o, bus.mem_req_o, bus.mem_addr_o} !== {2'b11, 32'h8000_0080})
            $display("FAIL rstmid_regrant got=%b addr=%h exp=11 addr=80000080",
                     {bus.lsu_gnt_o, bus.mem_req_o}, bus.mem_addr_o);
        else n_pass++;
        bus.lsu_req_i = 1'b0; bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'h0BAD_F00D;
        @(negedge clk_i);
        n_checks++;
        if ({bus.lsu_valid_o, bus.lsu_rdata_o, bus.fetch_data_o} !== {1'b1, 32'h0BAD_F00D, 32'h0})
            $display("FAIL rstmid_resp got=%b/%h/%h exp=1/0badf00d/0", bus.lsu_valid_o, bus.lsu_rdata_o, bus.fetch_data_o);
        else n_pass++;
        bus.mem_ready_i = 1'b0;
    endtask

    task automatic test_random();
        bit          f_on = 0, l_on = 0, busy = 0;
        int          f_since = 0, edge_n = 0, lat = 0;
        int          owner = 0, exp_gnt = 0, exp_vown = 0;
        logic [31:0] f_addr = 0, l_addr = 0, l_wdata = 0, exp_vdata = 0;
        logic        l_we = 0, t_we = 0;
        logic [3:0]  l_wstrb = 0, t_wstrb = 0;
        logic [31:0] t_addr = 0, t_wdata = 0, m_fdata = 0, m_ldata = 0;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            // Outputs produced by the edge just taken.
            if (exp_vown == 1) m_fdata = exp_vdata;
            if (exp_vown == 2) m_ldata = exp_vdata;
            n_checks++;
            if ({bus.fetch_gnt_o, bus.lsu_gnt_o} !== {exp_gnt == 1, exp_gnt == 2})
                $display("FAIL rnd_gnt cyc=%0d got=%b exp_owner=%0d", cyc, {bus.fetch_gnt_o, bus.lsu_gnt_o}, exp_gnt);
            else n_pass++;
            n_checks++;
            if ({bus.fetch_valid_o, bus.lsu_valid_o, bus.timeout_o} !== {exp_vown == 1, exp_vown == 2, 1'b0})
                $display("FAIL rnd_valid cyc=%0d got=%b exp_owner=%0d",
                         cyc, {bus.fetch_valid_o, bus.lsu_valid_o, bus.timeout_o}, exp_vown);
            else n_pass++;
            n_checks++;
            if ({bus.fetch_data_o, bus.lsu_rdata_o} !== {m_fdata, m_ldata})
                $display("FAIL rnd_data cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.fetch_data_o, bus.lsu_rdata_o, m_fdata, m_ldata);
            else n_pass++;
            n_checks++;
            if ({bus.mem_req_o, bus.busy_o} !== {busy, busy})
                $display("FAIL rnd_busy cyc=%0d got=%b exp=%b%b", cyc, {bus.mem_req_o, bus.busy_o}, busy, busy);
            else n_pass++;
            if (busy) begin
                n_checks++;
                if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wstrb_o} !== {t_we, t_addr, t_wstrb} ||
                    (owner == 2 && bus.mem_wdata_o !== t_wdata))
                    $display("FAIL rnd_mem cyc=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h", cyc, bus.mem_we_o,
                             bus.mem_addr_o, bus.mem_wstrb_o, bus.mem_wdata_o, t_we, t_addr, t_wstrb, t_wdata);
                else n_pass++;
            end
            // Requesters: drop after grant, raise new requests at random.
            if (exp_gnt == 1) f_on = 0;
            if (exp_gnt == 2) l_on = 0;
            if (!f_on && $urandom_range(0, 2) == 0) begin
                f_on = 1; f_addr = $urandom; f_since = edge_n;
            end
            if (!l_on && $urandom_range(0, 1) == 0) begin
                l_on = 1; l_we = 1'($urandom_range(0, 1)); l_addr = $urandom;
                l_wdata = $urandom; l_wstrb = 4'($urandom_range(1, 15));
            end
            bus.fetch_req_i  = f_on;
            bus.fetch_addr_i = f_on ? f_addr : $urandom;
            bus.lsu_req_i    = l_on;
            bus.lsu_we_i     = l_on ? l_we : 1'($urandom_range(0, 1));
            bus.lsu_addr_i   = l_on ? l_addr : $urandom;
            bus.lsu_wdata_i  = l_on ? l_wdata : $urandom;
            bus.lsu_wstrb_i  = l_on ? l_wstrb : 4'($urandom_range(0, 15));
            // Memory: answer after a random latency; stray ready while idle.
            bus.mem_rdata_i = $urandom;
            if (busy) begin
                bus.mem_ready_i = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                bus.mem_ready_i = ($urandom_range(0, 3) == 0);
            end
            // Prediction for the coming edge.
            exp_gnt  = 0;
            exp_vown = 0;
            if (busy) begin
                if (bus.mem_ready_i) begin
                    exp_vown  = owner;
                    exp_vdata = (owner == 2 && t_we) ? 32'h0 : bus.mem_rdata_i;
                    busy      = 0;
                end
            end else if (f_on || l_on) begin
                if (f_on && (!l_on || (edge_n - f_since) >= MAX_WAIT)) begin
                    exp_gnt = 1; owner = 1;
                    t_we = 0; t_addr = f_addr; t_wdata = 0; t_wstrb = 0;
                end else begin
                    exp_gnt = 2; owner = 2;
                    t_we = l_we; t_addr = l_addr; t_wdata = l_wdata; t_wstrb = l_we ? l_wstrb : 4'h0;
                end
                busy = 1;
                lat  = $urandom_range(0, 3);
            end
            edge_n++;
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_fetch_only();
        test_lsu_write();
        test_contention();
        test_timeout();
        test_ready_timeout_race();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end
endmodule
`default_nettype wire
